alu_operand_loader: RTL and testbench
=====================================

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: SYNC_NIB, default 4'hA, required header sync nibble.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ena  input  1  block enable; low freezes all state.
REQ-006 in_data  input  8  byte stream from pad inputs.
REQ-007 in_valid  input  1  in_data holds a byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 op_a  output  8  operand A to the ALU.
REQ-010 op_b  output  8  operand B to the ALU.
REQ-011 op_code  output  4  ALU opcode.
REQ-012 op_valid  output  1  op_a/op_b/op_code form a complete command.
REQ-013 op_ready  input  1  ALU consumes the command this cycle.
REQ-014 frame_err  output  1  one-cycle pulse on a dropped frame.
REQ-015 frame_cnt  output  8  count of frames handed to the ALU.

Function
REQ-016 Byte transfer SHALL occur on a rising edge with in_valid && in_ready.
REQ-017 in_ready SHALL be combinational: ena && state != PRESENT.
REQ-018 Frame: header {SYNC_NIB, opcode}, then A, then B; bytes are stored only on transfer.
REQ-019 States IDLE, GET_A, GET_B, PRESENT (plus GET_CHK per REQ-030); one transition per transfer.
REQ-020 IDLE: header with [7:4]==SYNC_NIB -> latch op_code, go GET_A; otherwise frame_err=1 next cycle, stay IDLE.
REQ-021 GET_A: latch op_a, go GET_B. GET_B: latch op_b, go PRESENT.
REQ-022 PRESENT: op_valid=1, outputs stable; op_ready=1 -> IDLE next cycle, frame_cnt+1.
REQ-023 op_valid SHALL be registered, asserted the cycle after the B (or checksum) transfer.
REQ-024 frame_cnt SHALL wrap 255 -> 0 silently.
REQ-025 ena=0: no transfers, no state, counter or output change; op_ready ignored; frame_err held 0.
REQ-026 op_ready outside PRESENT SHALL be ignored.
REQ-027 Minimum frame-to-frame period: 4 cycles (5 with checksum).

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, op_a=0, op_b=0, op_code=0, op_valid=0, frame_err=0, frame_cnt=0, regardless of ena.
REQ-029 Reset mid-frame or in PRESENT SHALL discard the partial/pending command with no frame_err.

Configuration
REQ-030 LOADER_CHKSUM_EN defined: fourth byte checksum after B, state GET_CHK; checksum must equal header^A^B; match -> PRESENT; mismatch -> frame_err pulse, IDLE, operands not presented.
REQ-031 LOADER_CHKSUM_EN undefined: 3-byte frame, GET_B goes directly to PRESENT, GET_CHK absent.

Structure
REQ-032 Shared package alu_pkg SHALL hold the opcode typedef (4-bit), loader state enum and SYNC_NIB default constant.
REQ-033 No sub-module; single flat module of about 150-250 lines.

Verification
REQ-034 After reset, bytes 0xA3,0x12,0x34 with op_ready=1 -> op_valid one cycle after 0x34, op_code=3, op_a=0x12, op_b=0x34; frame_cnt=1.
REQ-035 Header 0x53 -> frame_err pulse of exactly one cycle, state IDLE, next 0xA1,0x01,0x02 accepted normally.
REQ-036 In PRESENT with op_ready=0 for 10 cycles -> in_ready=0, op_valid=1, outputs stable; op_ready=1 -> IDLE next cycle.
REQ-037 ena=0 during GET_A with in_valid=1 -> no byte stored; restore ena -> frame completes with correct values.
REQ-038 256 good frames -> frame_cnt returns to 0; rst asserted in GET_B -> op_valid=0, frame_cnt=0.
REQ-039 With LOADER_CHKSUM_EN: 0xA2,0x0F,0xF0,0x5D presented; checksum 0x00 -> frame_err, no op_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand loader.
// The GET_CHK state exists only when LOADER_CHKSUM_EN is defined.
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam logic [3:0] SYNC_NIB_DEFAULT = 4'hA;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        PRESENT = 3'd3
`ifdef LOADER_CHKSUM_EN
        ,
        GET_CHK = 3'd4
`endif
    } loader_state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Byte-stream input and ALU command output of the operand loader.
// The slave modport is the loader; the master modport is its environment.
interface alu_operand_loader_if;
    import alu_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    logic [7:0] op_a;
    logic [7:0] op_b;
    opcode_t    op_code;
    logic       op_valid;
    logic       op_ready;

    modport master (
        output in_data, in_valid, op_ready,
        input  in_ready, op_a, op_b, op_code, op_valid
    );

    modport slave (
        input  in_data, in_valid, op_ready,
        output in_ready, op_a, op_b, op_code, op_valid
    );

endinterface

// File: rtl/alu_operand_loader.sv
// Assembles {SYNC_NIB, opcode}, A, B byte frames into one ALU command.
// Define LOADER_CHKSUM_EN to require a trailing header^A^B checksum byte.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter logic [3:0] SYNC_NIB = SYNC_NIB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    alu_operand_loader_if.slave  bus,
    output logic                 frame_err,
    output logic [7:0]           frame_cnt
);

    loader_state_t state;
    logic [7:0]    op_a_q;
    logic [7:0]    op_b_q;
    opcode_t       op_code_q;
    logic          op_valid_q;
    logic          in_xfer;

    // Ready drops while a command is held so the next frame cannot overwrite it.
    assign bus.in_ready = ena && (state != PRESENT);
    assign in_xfer      = bus.in_valid && bus.in_ready;

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_code  = op_code_q;
    assign bus.op_valid = op_valid_q;

`ifdef LOADER_CHKSUM_EN
    logic [7:0] chk_expected;
    assign chk_expected = {SYNC_NIB, op_code_q} ^ op_a_q ^ op_b_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_a_q     <= 8'h00;
            op_b_q     <= 8'h00;
            op_code_q  <= 4'h0;
            op_valid_q <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'h00;
        end else if (!ena) begin
            frame_err  <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        if (bus.in_data[7:4] == SYNC_NIB) begin
                            op_code_q <= bus.in_data[3:0];
                            state     <= GET_A;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                GET_A: begin
                    if (in_xfer) begin
                        op_a_q <= bus.in_data;
                        state  <= GET_B;
                    end
                end

                GET_B: begin
                    if (in_xfer) begin
                        op_b_q <= bus.in_data;
`ifdef LOADER_CHKSUM_EN
                        state  <= GET_CHK;
`else
                        state      <= PRESENT;
                        op_valid_q <= 1'b1;
`endif
                    end
                end

`ifdef LOADER_CHKSUM_EN
                GET_CHK: begin
                    if (in_xfer) begin
                        if (bus.in_data == chk_expected) begin
                            state      <= PRESENT;
                            op_valid_q <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            frame_err  <= 1'b1;
                        end
                    end
                end
`endif

                PRESENT: begin
                    if (bus.op_ready) begin
                        state      <= IDLE;
                        op_valid_q <= 1'b0;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    op_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed frames plus randomized
// good/bad frames checked against a frame-level reference model.
module tb_alu_operand_loader;

    localparam logic [3:0] SYNC = 4'hA;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       frame_err;
    logic [7:0] frame_cnt;

    alu_operand_loader_if bus();

    alu_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .bus       (bus),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_cnt  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Starts and ends at posedge+1; returns right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("in_ready_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame_bytes(input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input int gap);
        logic [7:0] hdr;
        hdr = {SYNC, op};
        send_byte(hdr, gap);
        send_byte(a, gap);
`ifdef LOADER_CHKSUM_EN
        send_byte(b, gap);
        send_byte(hdr ^ a ^ b, 0);
`else
        send_byte(b, 0);
`endif
    endtask

    // Called right after the last transfer edge; ends on a negedge.
    task automatic expect_present(input logic [19:0] cmd);
        @(negedge clk);
        check("present_valid", 32'(bus.op_valid), 32'd1);
        check("present_cmd", 32'({bus.op_code, bus.op_a, bus.op_b}), 32'(cmd));
        check("present_in_ready", 32'(bus.in_ready), 32'd0);
        check("present_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("present_err", 32'(frame_err), 32'd0);
    endtask

    // Starts on a negedge with a command presented; ends at posedge+1.
    task automatic consume(input int hold, input logic [19:0] cmd);
        repeat (hold) begin
            @(negedge clk);
            check("hold_cmd",
                  32'({bus.op_valid, bus.in_ready, bus.op_code, bus.op_a, bus.op_b}),
                  32'({2'b10, cmd}));
        end
        bus.op_ready = 1'b1;
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        @(negedge clk);
        check("done_valid", 32'(bus.op_valid), 32'd0);
        check("done_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check("done_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic good_frame(input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input int gap, input int hold);
        send_frame_bytes(op, a, b, gap);
        expect_present({op, a, b});
        consume(hold, {op, a, b});
    endtask

    task automatic bad_header(input logic [7:0] b);
        send_byte(b, 0);
        @(negedge clk);
        check("bad_hdr_err", 32'(frame_err), 32'd1);
        check("bad_hdr_valid", 32'(bus.op_valid), 32'd0);
        check("bad_hdr_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("bad_hdr_err_clear", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] start_cnt;
        logic [3:0] nib;

        rst          = 1'b1;
        ena          = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b0;

        // Reset applies even with ena low.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd", 32'({bus.op_valid, bus.op_code, bus.op_a, bus.op_b}), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_in_ready_ena0", 32'(bus.in_ready), 32'd0);
        ena = 1'b1;
        @(negedge clk);
        check("rst_in_ready_ena1", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic frame with op_ready held high from the start (ignored until PRESENT).
        bus.op_ready = 1'b1;
        send_frame_bytes(4'h3, 8'h12, 8'h34, 0);
        @(negedge clk);
        check("basic_valid", 32'(bus.op_valid), 32'd1);
        check("basic_cmd", 32'({bus.op_code, bus.op_a, bus.op_b}), 32'h31234);
        check("basic_cnt_before", 32'(frame_cnt), 32'd0);
        @(posedge clk); #1;
        bus.op_ready = 1'b0;
        exp_cnt = 8'd1;
        @(negedge clk);
        check("basic_valid_drop", 32'(bus.op_valid), 32'd0);
        check("basic_cnt_after", 32'(frame_cnt), 32'd1);
        @(posedge clk); #1;

        // Bad header, then a normal frame.
        bad_header(8'h53);
        good_frame(4'h1, 8'h01, 8'h02, 0, 0);

        // Long hold in PRESENT.
        good_frame(4'h9, 8'hDE, 8'hAD, 0, 10);

        // ena low while waiting for A: the offered byte must not be taken.
        send_byte({SYNC, 4'h6}, 0);
        ena          = 1'b0;
        bus.in_data  = 8'h77;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ena_off_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        ena          = 1'b1;
        bus.in_valid = 1'b0;
        send_byte(8'h5A, 0);
`ifdef LOADER_CHKSUM_EN
        send_byte(8'hC3, 0);
        send_byte({SYNC, 4'h6} ^ 8'h5A ^ 8'hC3, 0);
`else
        send_byte(8'hC3, 0);
`endif
        expect_present({4'h6, 8'h5A, 8'hC3});

        // ena low in PRESENT: op_ready ignored, nothing moves.
        ena          = 1'b0;
        bus.op_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ena_off_present",
                  32'({bus.op_valid, frame_err, frame_cnt}), 32'({2'b10, exp_cnt}));
        end
        ena = 1'b1;
        consume(0, {4'h6, 8'h5A, 8'hC3});

`ifdef LOADER_CHKSUM_EN
        // Checksum mismatch drops the frame; the right checksum is accepted.
        send_byte(8'hA2, 0);
        send_byte(8'h0F, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("chk_bad_err", 32'(frame_err), 32'd1);
        check("chk_bad_valid", 32'(bus.op_valid), 32'd0);
        check("chk_bad_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check("chk_bad_err_clear", 32'(frame_err), 32'd0);
        @(posedge clk); #1;
        good_frame(4'h2, 8'h0F, 8'hF0, 0, 0);
`endif

        // Randomized mix of good and bad frames.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                nib = 4'($urandom);
                if (nib == SYNC) nib = 4'h5;
                bad_header({nib, 4'($urandom)});
            end else begin
                good_frame(4'($urandom), 8'($urandom), 8'($urandom),
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            end
        end

        // 256 frames bring the counter back to where it started.
        start_cnt = frame_cnt;
        for (int i = 0; i < 256; i++) begin
            good_frame(4'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        end
        @(negedge clk);
        check("wrap_cnt", 32'(frame_cnt), 32'(start_cnt));
        @(posedge clk); #1;

        // Reset while waiting for B discards the partial frame quietly.
        send_byte({SYNC, 4'hC}, 0);
        send_byte(8'h99, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = 8'h00;
        @(negedge clk);
        check("midrst_cmd", 32'({bus.op_valid, bus.op_code, bus.op_a, bus.op_b}), 32'd0);
        check("midrst_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        good_frame(4'h7, 8'h11, 8'h22, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
